// File: rtl/sprite_anim_control.sv
// Purpose : draw/hold/erase/update sequencer that scans sprite pixels for the VGA animation path.
// Latency : Moore outputs; the first DRAW pixel appears one cycle after enable is seen in IDLE.
// Backpr. : none downstream; pause freezes only the HOLD interval, enable is honoured at frame boundaries.
//
// Optional build macro ANIM_VSYNC_EN: HOLD ends on vsync (with pause low) instead of after FRAME_TICKS cycles.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous, active-high reset
//   enable     - run animation while high (sampled in IDLE and UPDATE)
//   pause      - freezes the HOLD interval while high
//   vsync      - frame strobe, only used when ANIM_VSYNC_EN is defined
//   sprite_sel - sprite currently being scanned
//   x_off      - pixel column within the sprite
//   y_off      - pixel row within the sprite
//   writeEn    - VGA write enable (DRAW and ERASE)
//   erase      - datapath selects background colour (ERASE)
//   update_en  - one-cycle pulse that advances sprite positions
//   frame_done - one-cycle pulse on the UPDATE cycle
//   busy       - high in every state except IDLE
module sprite_anim_control #(
  parameter int NUM_SPRITES = 2,
  parameter int SPRITE_W    = 4,
  parameter int SPRITE_H    = 4,
  parameter int FRAME_TICKS = 833333,
  localparam int SW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int XW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
  localparam int YW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          pause,
  input  logic          vsync,
  output logic [SW-1:0] sprite_sel,
  output logic [XW-1:0] x_off,
  output logic [YW-1:0] y_off,
  output logic          writeEn,
  output logic          erase,
  output logic          update_en,
  output logic          frame_done,
  output logic          busy
);

  localparam logic [SW-1:0] S_LAST = SW'(NUM_SPRITES - 1);
  localparam logic [XW-1:0] X_LAST = XW'(SPRITE_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SPRITE_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_HOLD,
    S_ERASE,
    S_UPDATE
  } state_t;

  state_t state_q, state_d;

  logic [SW-1:0] s_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          scan;
  logic          last_pix;
  logic          hold_done;

  assign scan     = (state_q == S_DRAW) || (state_q == S_ERASE);
  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST) && (s_q == S_LAST);

  // Pixel scan counters: x fastest, then y, then sprite. Each wraps at its
  // parameter bound, so non-power-of-two sprite sizes scan correctly. They
  // are forced to zero outside the scan states so the next scan starts at 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_q <= '0;
      x_q <= '0;
      y_q <= '0;
    end else if (!scan) begin
      s_q <= '0;
      x_q <= '0;
      y_q <= '0;
    end else if (x_q == X_LAST) begin
      x_q <= '0;
      if (y_q == Y_LAST) begin
        y_q <= '0;
        s_q <= (s_q == S_LAST) ? '0 : s_q + SW'(1);
      end else begin
        y_q <= y_q + YW'(1);
      end
    end else begin
      x_q <= x_q + XW'(1);
    end
  end

`ifdef ANIM_VSYNC_EN
  // vsync is already synchronous to clock. It is only looked at while in
  // HOLD, so a strobe seen during DRAW/ERASE is simply dropped.
  assign hold_done = vsync && !pause;

  localparam int unused_frame_ticks = FRAME_TICKS;
`else
  localparam int HW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(FRAME_TICKS - 1);

  logic [HW-1:0] hold_q;
  logic          unused_vsync;

  assign unused_vsync = vsync;
  assign hold_done    = (hold_q == H_LAST) && !pause;

  // Counts only un-paused HOLD cycles; pause stretches HOLD indefinitely.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
    end else if (state_q != S_HOLD) begin
      hold_q <= '0;
    end else if (!pause) begin
      hold_q <= hold_done ? '0 : hold_q + HW'(1);
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // enable is checked only in IDLE and UPDATE, so dropping it mid-frame
  // still runs ERASE and the sprites are never left on screen.
  always_comb begin
    state_d    = state_q;
    writeEn    = 1'b0;
    erase      = 1'b0;
    update_en  = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (enable) state_d = S_DRAW;
      end
      S_DRAW: begin
        writeEn = 1'b1;
        if (last_pix) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (hold_done) state_d = S_ERASE;
      end
      S_ERASE: begin
        writeEn = 1'b1;
        erase   = 1'b1;
        if (last_pix) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        update_en  = 1'b1;
        frame_done = 1'b1;
        state_d    = enable ? S_DRAW : S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign sprite_sel = s_q;
  assign x_off      = x_q;
  assign y_off      = y_q;

endmodule

// File: tb/tb_sprite_anim_control.sv
module tb_sprite_anim_control;

  localparam int NS   = 2;
  localparam int W    = 2;
  localparam int H    = 2;
  localparam int FT   = 4;
  localparam int NPIX = NS * W * H;

  // {busy, writeEn, erase, update_en, frame_done}
  localparam logic [4:0] ID = 5'b00000;
  localparam logic [4:0] DR = 5'b11000;
  localparam logic [4:0] HD = 5'b10000;
  localparam logic [4:0] ER = 5'b11100;
  localparam logic [4:0] UP = 5'b10011;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic en_a    = 1'b0;
  logic pause_a = 1'b0;
  logic vsync   = 1'b0;
  logic en_b    = 1'b0;
  logic pause_b = 1'b0;

  logic [0:0] sel_a, x_a, y_a, sel_b, x_b, y_b;
  logic we_a, er_a, up_a, fd_a, busy_a;
  logic we_b, er_b, up_b, fd_b, busy_b;

  always #5 clock = ~clock;

  sprite_anim_control #(.NUM_SPRITES(NS), .SPRITE_W(W), .SPRITE_H(H), .FRAME_TICKS(FT)) dut_a (
    .clock(clock), .reset(reset), .enable(en_a), .pause(pause_a), .vsync(vsync),
    .sprite_sel(sel_a), .x_off(x_a), .y_off(y_a), .writeEn(we_a), .erase(er_a),
    .update_en(up_a), .frame_done(fd_a), .busy(busy_a)
  );

  sprite_anim_control #(.NUM_SPRITES(1), .SPRITE_W(1), .SPRITE_H(1), .FRAME_TICKS(1)) dut_b (
    .clock(clock), .reset(reset), .enable(en_b), .pause(pause_b), .vsync(vsync),
    .sprite_sel(sel_b), .x_off(x_b), .y_off(y_b), .writeEn(we_b), .erase(er_b),
    .update_en(up_b), .frame_done(fd_b), .busy(busy_b)
  );

  wire [7:0] obs_a = {busy_a, we_a, er_a, up_a, fd_a, sel_a, y_a, x_a};
  wire [7:0] obs_b = {busy_b, we_b, er_b, up_b, fd_b, sel_b, y_b, x_b};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic       en;
    logic       ps;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic en, input logic ps, input logic [4:0] fl, input int pix);
    vec_t v;
    v.en  = en;
    v.ps  = ps;
    v.exp = {fl, 3'(pix)};
    tbl.push_back(v);
  endfunction

  // Reference model: frame phase plus a linear pixel / hold index.
  int m_ph;   // 0 idle, 1 draw, 2 hold, 3 erase, 4 update
  int m_idx;

  function automatic logic [7:0] m_exp();
    int s, y, x;
    s = m_idx / (W * H);
    y = (m_idx % (W * H)) / W;
    x = m_idx % W;
    case (m_ph)
      1:       m_exp = {DR, 1'(s), 1'(y), 1'(x)};
      2:       m_exp = {HD, 3'b000};
      3:       m_exp = {ER, 1'(s), 1'(y), 1'(x)};
      4:       m_exp = {UP, 3'b000};
      default: m_exp = {ID, 3'b000};
    endcase
  endfunction

  task automatic m_step(input logic en, input logic ps, input logic vs);
    case (m_ph)
      0: if (en) begin m_ph = 1; m_idx = 0; end
      1: if (m_idx == NPIX - 1) begin m_ph = 2; m_idx = 0; end else m_idx++;
      2: begin
`ifdef ANIM_VSYNC_EN
        if (vs && !ps) begin m_ph = 3; m_idx = 0; end
`else
        if (!ps) begin
          if (m_idx == FT - 1) begin m_ph = 3; m_idx = 0; end else m_idx++;
        end
`endif
      end
      3: if (m_idx == NPIX - 1) m_ph = 4; else m_idx++;
      default: begin m_ph = en ? 1 : 0; m_idx = 0; end
    endcase
  endtask

  initial begin
    logic [7:0] pat [4];
    logic en_r, ps_r, vs_r;

    // Reset state on both instances.
    #12;
    check("reset_a", obs_a, 8'h00);
    check("reset_b", obs_b, 8'h00);
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("post_release_a", obs_a, 8'h00);

`ifndef ANIM_VSYNC_EN
    // Frame 1: plain frame, period 21.
    add(0, 0, ID, 0);
    for (int k = 0; k < 8; k++) add(1, 0, DR, k);
    for (int k = 0; k < 4; k++) add(1, 0, HD, 0);
    for (int k = 0; k < 8; k++) add(1, 0, ER, k);
    add(1, 0, UP, 0);
    // Frame 2: enable dropped during the 3rd DRAW cycle.
    add(1, 0, DR, 0);
    add(1, 0, DR, 1);
    add(1, 0, DR, 2);
    for (int k = 3; k < 8; k++) add(0, 0, DR, k);
    for (int k = 0; k < 4; k++) add(0, 0, HD, 0);
    for (int k = 0; k < 8; k++) add(0, 0, ER, k);
    add(0, 0, UP, 0);
    add(0, 0, ID, 0);
    add(0, 0, ID, 0);
    // Frame 3: pause high for the first 10 HOLD cycles -> HOLD is 14 cycles.
    for (int k = 0; k < 8; k++) add(1, 0, DR, k);
    add(1, 0, HD, 0);
    for (int k = 0; k < 10; k++) add(1, 1, HD, 0);
    for (int k = 0; k < 3; k++) add(1, 0, HD, 0);
    for (int k = 0; k < 8; k++) add(1, 0, ER, k);
    add(0, 0, UP, 0);
    add(0, 0, ID, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      en_a    = tbl[i].en;
      pause_a = tbl[i].ps;
      tick();
      check($sformatf("vec%0d", i), obs_a, tbl[i].exp);
    end

    // Reset asserted in the 5th ERASE cycle.
    en_a = 1'b1;
    tick();
    for (int k = 0; k < 7 + 4 + 5; k++) tick();
    check("erase5", obs_a, {ER, 3'd4});
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_erase", obs_a, 8'h00);
    tick();
    reset = 1'b0;
    check("after_rst_idle", obs_a, 8'h00);
    tick();
    check("after_rst_draw0", obs_a, {DR, 3'd0});
    en_a = 1'b0;
    for (int k = 0; k < 21; k++) tick();
    check("after_rst_done", obs_a, {ID, 3'd0});

    // Degenerate 1x1x1 sprite, FRAME_TICKS=1: period 4.
    pat[0] = {DR, 3'd0};
    pat[1] = {HD, 3'd0};
    pat[2] = {ER, 3'd0};
    pat[3] = {UP, 3'd0};
    en_b = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("tiny%0d", k), obs_b, pat[k % 4]);
    end
    en_b = 1'b0;
    tick();
    tick();
`else
    // vsync during DRAW is ignored; vsync 6 cycles into HOLD starts ERASE.
    en_a = 1'b1;
    tick();
    check("vs_draw0", obs_a, {DR, 3'd0});
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    check("vs_draw1", obs_a, {DR, 3'd1});
    for (int k = 2; k < 8; k++) tick();
    check("vs_draw7", obs_a, {DR, 3'd7});
    for (int k = 0; k < 7; k++) tick();
    check("vs_hold7", obs_a, {HD, 3'd0});
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    check("vs_erase0", obs_a, {ER, 3'd0});
    en_a = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("vs_idle", obs_a, {ID, 3'd0});
`endif

    // Randomized run against the reference model.
    reset = 1'b1;
    en_a = 1'b0;
    pause_a = 1'b0;
    vsync = 1'b0;
    tick();
    reset = 1'b0;
    m_ph  = 0;
    m_idx = 0;
    check("rand_reset", obs_a, m_exp());
    en_r = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 24) == 0) en_r = ~en_r;
      ps_r = ($urandom_range(0, 3) == 0);
      vs_r = ($urandom_range(0, 7) == 0);
      en_a    = en_r;
      pause_a = ps_r;
      vsync   = vs_r;
      tick();
      m_step(en_r, ps_r, vs_r);
      check($sformatf("rand%0d", n), obs_a, m_exp());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_anim_control.md
Name: sprite_anim_control

Overview:
- Parametrised draw/hold/erase/update sequencer for the VGA animation path.
- Each frame it scans every pixel of NUM_SPRITES sprites to draw them, then holds for a frame interval.
- It then scans the same pixels again with erase asserted, and pulses a position-update enable.
- Sits between the top-level key/switch logic and the datapath that turns sprite_sel/x_off/y_off into VGA adapter x, y and colour.

Parameters:
- NUM_SPRITES, 2: number of sprites drawn per frame (>=1).
- SPRITE_W, 4: sprite width in pixels (>=1).
- SPRITE_H, 4: sprite height in pixels (>=1).
- FRAME_TICKS, 833333: HOLD duration in clock cycles (>=1); the default gives 60 Hz at 50 MHz.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run animation while high.
- pause  in  1  freezes the HOLD counter while high.
- vsync  in  1  frame strobe; used only with ANIM_VSYNC_EN.
- sprite_sel  out  max(1,$clog2(NUM_SPRITES))  sprite currently being scanned.
- x_off  out  max(1,$clog2(SPRITE_W))  pixel column within the sprite.
- y_off  out  max(1,$clog2(SPRITE_H))  pixel row within the sprite.
- writeEn  out  1  VGA write enable.
- erase  out  1  datapath selects background colour.
- update_en  out  1  one-cycle pulse that advances sprite positions.
- frame_done  out  1  one-cycle pulse on the last UPDATE cycle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; sprite/x/y counters=0; hold counter=0.
  - All outputs 0 while reset is high and on the first cycle after release.
- Outputs are decoded from the registered state and counters (Moore); there are no combinational input-to-output paths.
- States:
  - IDLE: all outputs 0. Goes to DRAW when enable=1, otherwise stays.
  - DRAW:
    - writeEn=1, erase=0.
    - Scans pixels, one per cycle: x_off fastest, then y_off, then sprite_sel, all starting from 0.
    - At x_off=SPRITE_W-1, y_off=SPRITE_H-1, sprite_sel=NUM_SPRITES-1, counters clear to 0 and the state goes to HOLD.
    - Duration: exactly NUM_SPRITES*SPRITE_W*SPRITE_H cycles.
  - HOLD:
    - writeEn=0, erase=0.
    - The hold counter increments each cycle in which pause=0.
    - When the counter reaches FRAME_TICKS-1 with pause=0, it clears and the state goes to ERASE.
    - With pause=0 throughout, HOLD lasts FRAME_TICKS cycles.
  - ERASE: writeEn=1, erase=1. Same scan order and duration as DRAW; on the last pixel the state goes to UPDATE.
  - UPDATE:
    - update_en=1 and frame_done=1 for exactly 1 cycle.
    - Next state is DRAW if enable=1, otherwise IDLE.
- Frame period with pause=0: 2*NUM_SPRITES*SPRITE_W*SPRITE_H + FRAME_TICKS + 1 cycles.
- Counters:
  - Each counter wraps at its parameter bound, not at its power of two.
  - Counters hold at 0 outside DRAW and ERASE.
- enable deasserted mid-frame: the current frame completes through ERASE and UPDATE, then the block enters IDLE. A sprite is never left drawn on screen.
- pause:
  - Affects HOLD only.
  - DRAW and ERASE scans ignore pause.
  - pause held indefinitely keeps the block in HOLD with the sprites displayed.
- Reset asserted mid-scan: immediate return to IDLE. The partially drawn image is not erased; the software/top level re-clears the screen.
- Degenerate parameters:
  - NUM_SPRITES=1, SPRITE_W=1, SPRITE_H=1: DRAW and ERASE each last 1 cycle.
  - FRAME_TICKS=1: HOLD lasts 1 cycle.

Optional Feature:
- Macro: ANIM_VSYNC_EN.
- Defined:
  - HOLD exits on the first cycle with vsync=1 and pause=0, after at least one cycle spent in HOLD; FRAME_TICKS and the hold counter are unused.
  - vsync is treated as already synchronous to clock.
  - A vsync pulse arriving outside HOLD is ignored, not latched.
- Not defined: vsync is ignored and HOLD uses FRAME_TICKS as described above.

Test Plan:
- Params NUM_SPRITES=2, SPRITE_W=2, SPRITE_H=2, FRAME_TICKS=4; reset, then enable=1:
  - DRAW lasts 8 cycles, with (sprite,y,x) = (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0)…(1,1,1) and writeEn=1, erase=0.
  - HOLD lasts 4 cycles with writeEn=0.
  - ERASE lasts 8 cycles with erase=1.
  - update_en and frame_done are 1 for 1 cycle; frame period is 21 cycles.
- Same params; enable dropped during the 3rd DRAW cycle -> HOLD, ERASE and UPDATE still complete, then IDLE with busy=0; no further writeEn.
- Same params; pause=1 for 10 cycles entering HOLD -> HOLD lasts 14 cycles; DRAW and ERASE timing unchanged.
- Reset asserted during the 5th ERASE cycle -> all outputs 0 in the same cycle; after release, with enable=1, the next DRAW starts at (0,0,0).
- NUM_SPRITES=1, SPRITE_W=1, SPRITE_H=1, FRAME_TICKS=1 with enable=1 -> repeating pattern DRAW, HOLD, ERASE, UPDATE with period 4 cycles.
- ANIM_VSYNC_EN defined:
  - vsync pulsed 6 cycles after HOLD entry -> ERASE starts on the next cycle.
  - A vsync pulse during DRAW -> no effect.
